// File: rtl/lisp_pkg.sv
// Shared types and constants for the list-cell engine: tagged 16-bit words,
// 12-bit cell pointers, command opcodes and FSM state encoding.
package lisp_pkg;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 16;
  localparam int TAG_W      = 4;
  localparam int RD_TIMEOUT = 64;

  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [TAG_W-1:0]  tag_t;

  typedef enum logic [1:0] {
    OP_CONS = 2'b00,
    OP_CAR  = 2'b01,
    OP_CDR  = 2'b10,
    OP_BAD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_CAR,
    S_WR_CDR,
    S_RD_REQ,
    S_RD_WAIT,
    S_RESP
  } state_e;

  localparam tag_t  TAG_CONS = 4'h1;
  localparam tag_t  TAG_INT  = 4'h2;
  localparam word_t NIL      = 16'h0000;
  localparam ptr_t  PTR_MAX  = '1;

  function automatic tag_t tag_of(input word_t w);
    return w[DATA_W-1 -: TAG_W];
  endfunction

endpackage

// File: rtl/cons_unit.sv
// CONS/CAR/CDR engine: turns one command into a memory append or read
// sequence and returns a single tagged-word response.
module cons_unit
  import lisp_pkg::*;
#(
  parameter int TIMEOUT = RD_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              req,
  output logic [ADDR_W-1:0] addr_in,
  input  logic              data_ready,
  input  logic [DATA_W-1:0] data_out,
  output logic              write_enable,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] write_result_addr
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_reg, state_next;
  word_t            a_reg, a_next;
  word_t            b_reg, b_next;
  ptr_t             addr_reg, addr_next;
  word_t            rsp_data_reg, rsp_data_next;
  logic             rsp_err_reg, rsp_err_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  op_e  op;
  ptr_t cmd_ptr;
  assign op      = op_e'(cmd_op);
  assign cmd_ptr = cmd_a[ADDR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      a_reg        <= NIL;
      b_reg        <= NIL;
      addr_reg     <= '0;
      rsp_data_reg <= NIL;
      rsp_err_reg  <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      addr_reg     <= addr_next;
      rsp_data_reg <= rsp_data_next;
      rsp_err_reg  <= rsp_err_next;
      cnt_reg      <= cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    addr_next     = addr_reg;
    rsp_data_next = rsp_data_reg;
    rsp_err_next  = rsp_err_reg;
    cnt_next      = cnt_reg;
    cmd_ready     = 1'b0;
    req           = 1'b0;
    write_enable  = 1'b0;
    write_data    = NIL;

    unique case (state_reg)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          a_next   = cmd_a;
          b_next   = cmd_b;
          cnt_next = '0;
          // Rejected commands skip memory entirely and answer NIL with err
          if (op == OP_CONS) begin
            state_next = S_WR_CAR;
          end else if ((op == OP_CAR || op == OP_CDR) &&
                       tag_of(cmd_a) == TAG_CONS &&
                       !(op == OP_CDR && cmd_ptr == PTR_MAX)) begin
            addr_next  = (op == OP_CDR) ? cmd_ptr + ptr_t'(1) : cmd_ptr;
            state_next = S_RD_REQ;
          end else begin
            rsp_data_next = NIL;
            rsp_err_next  = 1'b1;
            state_next    = S_RESP;
          end
        end
      end
      S_WR_CAR: begin
        write_enable = 1'b1;
        write_data   = a_reg;
        state_next   = S_WR_CDR;
      end
      S_WR_CDR: begin
        write_enable = 1'b1;
        write_data   = b_reg;
        // write_result_addr still reports the car word written last cycle
        if (write_result_addr == PTR_MAX) begin
          rsp_data_next = NIL;
          rsp_err_next  = 1'b1;
        end else begin
          rsp_data_next = {TAG_CONS, write_result_addr};
          rsp_err_next  = 1'b0;
        end
        state_next = S_RESP;
      end
      S_RD_REQ: begin
        req        = 1'b1;
        cnt_next   = '0;
        state_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (data_ready) begin
          rsp_data_next = data_out;
          rsp_err_next  = 1'b0;
          state_next    = S_RESP;
        end else if (cnt_reg == CNT_LAST) begin
          rsp_data_next = NIL;
          rsp_err_next  = 1'b1;
          state_next    = S_RESP;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign rsp_valid = (state_reg == S_RESP);
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;
  assign addr_in   = addr_reg;

endmodule

// File: tb/tb_cons_unit.sv
// Directed bench for cons_unit with a small append/read memory model
// (appends start at address 1, read data arrives one cycle after req).
module tb_cons_unit;
  import lisp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        req;
  logic [11:0] addr_in;
  logic        data_ready;
  logic [15:0] data_out;
  logic        write_enable;
  logic [15:0] write_data;
  logic [11:0] write_result_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cons_unit dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .req(req), .addr_in(addr_in),
    .data_ready(data_ready), .data_out(data_out),
    .write_enable(write_enable), .write_data(write_data),
    .write_result_addr(write_result_addr)
  );

  // memory model
  logic [15:0] mem [0:4095];
  logic [11:0] next_free = 12'h001;
  logic [11:0] last_addr = 12'h000;
  logic        mem_dr = 1'b0;
  logic [15:0] mem_q = '0;
  logic        mute = 1'b0;
  logic        force_dr = 1'b0;
  logic [15:0] force_q = '0;

  always @(posedge clk) begin
    if (write_enable) begin
      mem[next_free] <= write_data;
      last_addr      <= next_free;
      next_free      <= next_free + 12'h001;
    end
    mem_dr <= req && !mute;
    mem_q  <= mem[addr_in];
  end

  assign write_result_addr = last_addr;
  assign data_ready        = mem_dr | force_dr;
  assign data_out          = force_dr ? force_q : mem_q;

  // strobe monitor
  int we_cnt = 0;
  int req_cnt = 0;
  int excl_err = 0;
  always @(negedge clk) begin
    if (write_enable) we_cnt++;
    if (req) req_cnt++;
    if (req && write_enable) excl_err++;
    if ((cmd_ready || rsp_valid) && (req || write_enable)) excl_err++;
  end

  int cycles;

  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int limit);
    cycles = 0;
    while (cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) begin
      failures++;
      $display("FAIL rsp_timeout: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, cycles);
    end
  endtask

  task automatic retire();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, req, write_enable} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl: got rdy/vld/err/req/we=%b, required 10000",
               {cmd_ready, rsp_valid, rsp_err, req, write_enable});
    end
    checks++;
    if ({rsp_data, addr_in, write_data} !== 44'h0) begin
      failures++;
      $display("FAIL reset_data: got data=%h addr=%h wdata=%h, required 0", rsp_data, addr_in, write_data);
    end
    $display("reset: cmd_ready=%0b rsp_data=%h", cmd_ready, rsp_data);
  endtask

  task automatic test_cons();
    int we0;
    we0 = we_cnt;
    issue(OP_CONS, 16'h2005, 16'h0000);
    wait_rsp(10);
    checks++;
    if (cycles !== 3) begin
      failures++;
      $display("FAIL cons_latency: got %0d cycles, required 3", cycles);
    end
    checks++;
    if (rsp_data !== 16'h1001 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL cons_rsp: got data=%h err=%0b, required 1001 err=0", rsp_data, rsp_err);
    end
    checks++;
    if (we_cnt - we0 !== 2) begin
      failures++;
      $display("FAIL cons_we_cycles: got %0d, required 2", we_cnt - we0);
    end
    checks++;
    if (mem[1] !== 16'h2005 || mem[2] !== 16'h0000) begin
      failures++;
      $display("FAIL cons_mem: got mem1=%h mem2=%h, required 2005 0000", mem[1], mem[2]);
    end
    $display("CONS 2005 0000 -> data=%h err=%0b cycles=%0d", rsp_data, rsp_err, cycles);
    retire();
  endtask

  task automatic test_read(input string name, input logic [1:0] op, input logic [15:0] ptr,
                           input logic [11:0] exp_addr, input logic [15:0] exp_data);
    int r0;
    r0 = req_cnt;
    issue(op, ptr, 16'hFFFF);
    wait_rsp(10);
    checks++;
    if (rsp_data !== exp_data || rsp_err !== 1'b0 || cycles !== 3) begin
      failures++;
      $display("FAIL %s_rsp: got data=%h err=%0b cycles=%0d, required %h err=0 cycles=3",
               name, rsp_data, rsp_err, cycles, exp_data);
    end
    checks++;
    if (addr_in !== exp_addr || req_cnt - r0 !== 1) begin
      failures++;
      $display("FAIL %s_addr: got addr=%h reqs=%0d, required %h reqs=1", name, addr_in, req_cnt - r0, exp_addr);
    end
    $display("%s %h -> addr=%h data=%h err=%0b", name, ptr, addr_in, rsp_data, rsp_err);
    retire();
  endtask

  task automatic test_error(input string name, input logic [1:0] op, input logic [15:0] ptr);
    int r0;
    int w0;
    r0 = req_cnt;
    w0 = we_cnt;
    issue(op, ptr, 16'h0000);
    wait_rsp(10);
    checks++;
    if (rsp_err !== 1'b1 || rsp_data !== 16'h0000 || cycles !== 1) begin
      failures++;
      $display("FAIL %s_err: got err=%0b data=%h cycles=%0d, required err=1 data=0000 cycles=1",
               name, rsp_err, rsp_data, cycles);
    end
    checks++;
    if (req_cnt != r0 || we_cnt != w0) begin
      failures++;
      $display("FAIL %s_nostrobe: got reqs=%0d writes=%0d, required 0 0", name, req_cnt - r0, we_cnt - w0);
    end
    $display("%s %h -> err=%0b data=%h", name, ptr, rsp_err, rsp_data);
    retire();
  endtask

  task automatic test_hold();
    int bad;
    bad = 0;
    issue(OP_CONS, 16'h3007, 16'h1001);
    wait_rsp(10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== 16'h1003 || rsp_err !== 1'b0 || cmd_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_stable: %0d unstable cycles (data=%h vld=%0b rdy=%0b), required 0 with data=1003",
               bad, rsp_data, rsp_valid, cmd_ready);
    end
    retire();
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_retire: got rdy=%0b vld=%0b, required 1 0", cmd_ready, rsp_valid);
    end
    $display("hold: data=1003 held 5 cycles, bad=%0d", bad);
  endtask

  task automatic test_timeout();
    mute = 1'b1;
    issue(OP_CAR, 16'h1003, 16'h0000);
    wait_rsp(200);
    checks++;
    if (cycles !== RD_TIMEOUT + 2 || rsp_err !== 1'b1 || rsp_data !== 16'h0000) begin
      failures++;
      $display("FAIL timeout: got cycles=%0d err=%0b data=%h, required %0d err=1 data=0000",
               cycles, rsp_err, rsp_data, RD_TIMEOUT + 2);
    end
    $display("timeout: cycles=%0d err=%0b", cycles, rsp_err);
    retire();
    mute = 1'b0;
  endtask

  task automatic test_reset_mid();
    int r0;
    int w0;
    int bad;
    bad = 0;
    mute = 1'b1;
    issue(OP_CDR, 16'h1001, 16'h0000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mute = 1'b0;
    r0 = req_cnt;
    w0 = we_cnt;
    force_q = 16'hBEEF;
    force_dr = 1'b1;
    @(negedge clk);
    force_dr = 1'b0;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, req, write_enable} !== 5'b10000 || {rsp_data, addr_in, write_data} !== 44'h0) begin
      failures++;
      $display("FAIL midreset_outputs: got rdy/vld/err/req/we=%b data=%h addr=%h, required 10000 0 0",
               {cmd_ready, rsp_valid, rsp_err, req, write_enable}, rsp_data, addr_in);
    end
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || req_cnt != r0 || we_cnt != w0) begin
      failures++;
      $display("FAIL midreset_ignore: bad=%0d reqs=%0d writes=%0d, required 0 0 0", bad, req_cnt - r0, we_cnt - w0);
    end
    $display("mid-op reset: cmd_ready=%0b rsp_valid=%0b", cmd_ready, rsp_valid);
  endtask

  task automatic test_back_to_back();
    test_read("CAR", OP_CAR, 16'h1003, 12'h003, 16'h3007);
    test_read("CDR", OP_CDR, 16'h1003, 12'h004, 16'h1001);
  endtask

  initial begin
    test_reset();
    test_cons();
    test_read("CAR", OP_CAR, 16'h1001, 12'h001, 16'h2005);
    test_read("CDR", OP_CDR, 16'h1001, 12'h002, 16'h0000);
    test_error("CAR_int", OP_CAR, 16'h2001);
    test_error("CDR_wrap", OP_CDR, 16'h1FFF);
    test_error("BAD_op", 2'b11, 16'h1001);
    test_hold();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (excl_err != 0) begin
      failures++;
      $display("FAIL exclusivity: got %0d violating cycles, required 0", excl_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
